jtag_tdr_bank: RTL and testbench

Multi-channel JTAG test data register that generalises the single-instrument TDR into a bank of `N_CH` instrument slots behind one scan segment. Each scan frame carries a header (write flag, override flag, channel index) and a payload (scope + configuration). Per channel it provides an update handshake and overrun detection. It sits between the TAP controller's DR-phase strobes and up to `N_CH` instruments, or behind a SIB in a segmented chain.

---
 rtl/jtag_pkg.sv | 23 ++
 rtl/jtag_tdr_chan.sv | 77 +++++++
 rtl/jtag_tdr_bank.sv | 133 +++++++++++++
 tb/tb_jtag_tdr_bank.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/jtag_pkg.sv
// Shared frame geometry for the banked JTAG test data register.
// The header sits at the top of every scan frame; its bit positions are
// given as offsets from the frame MSB so they hold for any bank size.
package jtag_pkg;

    localparam int unsigned HDR_WR_FROM_MSB  = 0;  // write flag
    localparam int unsigned HDR_OVR_FROM_MSB = 1;  // override flag
    localparam int unsigned HDR_CH_FROM_MSB  = 2;  // MSB of channel index
    localparam int unsigned HDR_FLAG_BITS    = 2;  // wr + ovr

    // Width of the channel index field; never narrower than one bit.
    function automatic int unsigned jtag_ch_bits(input int unsigned n_ch);
        return (n_ch <= 2) ? 1 : $clog2(n_ch);
    endfunction

    // Total scan length: flags + channel index + scope + configuration.
    function automatic int unsigned jtag_frame_len(input int unsigned n_ch,
                                                   input int unsigned n_scope,
                                                   input int unsigned n_conf);
        return HDR_FLAG_BITS + jtag_ch_bits(n_ch) + n_scope + n_conf;
    endfunction

endpackage

// File: rtl/jtag_tdr_chan.sv
// One instrument slot of the bank: configuration, override select,
// update-pending handshake and sticky overrun flag.
module jtag_tdr_chan #(
    parameter int unsigned       N_CONF    = 8,
    parameter logic [N_CONF-1:0] INIT_CONF = '0
) (
    input  logic              tck,
    input  logic              trst,
    input  logic              wr_stb_i,     // update addressed this slot with wr=1
    input  logic              ovr_i,
    input  logic [N_CONF-1:0] conf_i,
    input  logic              ack_i,        // instrument took the pending config
    input  logic              clr_ovf_i,    // capture read this slot's status
    input  logic [N_CONF-1:0] cfi_i,
    output logic [N_CONF-1:0] cfo_o,
    output logic              upd_valid_o,
    output logic              ovr_o,
    output logic [N_CONF-1:0] cfg_o,
    output logic              ovf_o
);

    logic [N_CONF-1:0] cfg_q, cfg_d;
    logic              ovr_q, ovr_d;
    logic              pend_q, pend_d;
    logic              ovf_q, ovf_d;
    logic              accept;

    // A write lands if nothing is pending or the instrument acks in the same cycle.
    assign accept = wr_stb_i & (~pend_q | ack_i);

    // Next-state: ack clears pending, an accepted write re-arms it (set wins).
    always_comb begin
        // NOTE: every _d starts from its current value so no path leaves it unassigned (no latch).
        cfg_d  = cfg_q;
        ovr_d  = ovr_q;
        pend_d = pend_q;
        ovf_d  = ovf_q;
        if (ack_i) begin
            pend_d = 1'b0;
        end
        if (accept) begin
            cfg_d  = conf_i;
            ovr_d  = ovr_i;
            pend_d = 1'b1;
        end
        if (clr_ovf_i) begin
            ovf_d = 1'b0;
        end
        if (wr_stb_i && !accept) begin
            ovf_d = 1'b1;
        end
    end

    // Slot state register with synchronous reset.
    always_ff @(posedge tck) begin
        // NOTE: non-blocking assignments here so every flop samples pre-edge values.
        if (trst) begin
            // NOTE: the configuration store is plain flops, not a RAM, so it takes a reset value.
            cfg_q  <= INIT_CONF;
            ovr_q  <= 1'b0;
            pend_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            cfg_q  <= cfg_d;
            ovr_q  <= ovr_d;
            pend_q <= pend_d;
            ovf_q  <= ovf_d;
        end
    end

    assign cfo_o       = ovr_q ? cfg_q : cfi_i;
    assign upd_valid_o = pend_q;
    assign ovr_o       = ovr_q;
    assign cfg_o       = cfg_q;
    assign ovf_o       = ovf_q;

endmodule

// File: rtl/jtag_tdr_bank.sv
// Banked JTAG test data register: one scan segment fronting N_CH instrument
// slots. Holds the shift register, the channel pointer, strobe decode and
// the capture mux; per-slot state lives in jtag_tdr_chan.
module jtag_tdr_bank
    import jtag_pkg::*;
#(
    parameter int unsigned                 N_CH       = 4,
    parameter int unsigned                 N_CONF     = 8,
    parameter int unsigned                 N_SCOPE    = 4,
    parameter logic [N_CH*N_CONF-1:0]      INIT_VALUE = '0
) (
    input  logic                      tck,
    input  logic                      trst,
    input  logic                      select,
    input  logic                      capture_dr,
    input  logic                      shift_dr,
    input  logic                      update_dr,
    input  logic                      tdi,
    output logic                      tdo,
    input  logic [N_CH*N_CONF-1:0]    cfi,
    input  logic [N_CH*N_SCOPE-1:0]   sfi,
    output logic [N_CH*N_CONF-1:0]    cfo,
    output logic [N_CH-1:0]           upd_valid,
    input  logic [N_CH-1:0]           upd_ack
);

    localparam int unsigned CHB    = jtag_ch_bits(N_CH);
    localparam int unsigned L      = jtag_frame_len(N_CH, N_SCOPE, N_CONF);
    localparam int unsigned WR_BIT = L - 1 - HDR_WR_FROM_MSB;
    localparam int unsigned OV_BIT = L - 1 - HDR_OVR_FROM_MSB;
    localparam int unsigned CH_MSB = L - 1 - HDR_CH_FROM_MSB;
    // One extra bit so N_CH itself is representable (N_CH=256 with CHB=8).
    localparam logic [CHB:0] N_CH_LIM = N_CH[CHB:0];

    logic [L-1:0]       sr_q, sr_d;
    logic [CHB-1:0]     ch_q, ch_d;

    logic               do_upd, do_cap, do_shf;
    logic               fr_wr, fr_ovr, fr_ch_ok;
    logic [CHB-1:0]     fr_ch;
    logic [N_CONF-1:0]  fr_conf;

    logic [N_CH-1:0]    wr_stb, clr_ovf, ovr_st, ovf_st;
    logic [N_CONF-1:0]  cfg_st [N_CH];

    logic               cap_ovf, cap_ovr;
    logic [N_SCOPE-1:0] cap_sfi;
    logic [N_CONF-1:0]  cap_cfg;
    logic [L-1:0]       cap_frame;

    // Strobe priority: update over capture over shift, all gated by select.
    assign do_upd = select & update_dr;
    assign do_cap = select & capture_dr & ~update_dr;
    assign do_shf = select & shift_dr & ~capture_dr & ~update_dr;

    // Frame fields as currently held in the shift register; scope is ignored.
    assign fr_wr    = sr_q[WR_BIT];
    assign fr_ovr   = sr_q[OV_BIT];
    assign fr_ch    = sr_q[CH_MSB -: CHB];
    assign fr_conf  = sr_q[N_CONF-1:0];
    assign fr_ch_ok = ({1'b0, fr_ch} < N_CH_LIM);

    // Capture mux: status of the slot under the pointer, plus per-slot strobes.
    always_comb begin
        cap_ovf = 1'b0;
        cap_ovr = 1'b0;
        cap_sfi = '0;
        cap_cfg = '0;
        wr_stb  = '0;
        clr_ovf = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (ch_q == CHB'(c)) begin
                cap_ovf    = ovf_st[c];
                cap_ovr    = ovr_st[c];
                cap_sfi    = sfi[c*N_SCOPE +: N_SCOPE];
                cap_cfg    = cfg_st[c];
                clr_ovf[c] = do_cap;
            end
            wr_stb[c] = do_upd & fr_wr & fr_ch_ok & (fr_ch == CHB'(c));
        end
    end

    assign cap_frame = {cap_ovf, cap_ovr, ch_q, cap_sfi, cap_cfg};

    // Scan path and pointer next-state; an out-of-range channel changes nothing.
    always_comb begin
        sr_d = sr_q;
        ch_d = ch_q;
        if (do_cap) begin
            sr_d = cap_frame;
        end else if (do_shf) begin
            sr_d = {sr_q[L-2:0], tdi};
        end
        if (do_upd && fr_ch_ok) begin
            ch_d = fr_ch;
        end
    end

    // Shift register and channel pointer with synchronous reset.
    always_ff @(posedge tck) begin
        if (trst) begin
            sr_q <= '0;
            ch_q <= '0;
        end else begin
            sr_q <= sr_d;
            ch_q <= ch_d;
        end
    end

    assign tdo = sr_q[L-1];

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        jtag_tdr_chan #(
            .N_CONF    (N_CONF),
            .INIT_CONF (INIT_VALUE[c*N_CONF +: N_CONF])
        ) u_chan (
            .tck         (tck),
            .trst        (trst),
            .wr_stb_i    (wr_stb[c]),
            .ovr_i       (fr_ovr),
            .conf_i      (fr_conf),
            .ack_i       (upd_ack[c]),
            .clr_ovf_i   (clr_ovf[c]),
            .cfi_i       (cfi[c*N_CONF +: N_CONF]),
            .cfo_o       (cfo[c*N_CONF +: N_CONF]),
            .upd_valid_o (upd_valid[c]),
            .ovr_o       (ovr_st[c]),
            .cfg_o       (cfg_st[c]),
            .ovf_o       (ovf_st[c])
        );
    end

endmodule

// File: tb/tb_jtag_tdr_bank.sv
// Bench for jtag_tdr_bank: directed frame table, reset and out-of-range
// corner sequences, then random scans against a transaction-level model.
module tb_jtag_tdr_bank;

    localparam int L = 16;  // 2 + 2 + 4 + 8 for both instances below
    localparam logic [31:0] INIT_A = 32'h8C6B2F44;
    localparam logic [23:0] INIT_B = 24'h334455;

    logic        tck = 1'b0;
    logic        trst, select, select_b, capture_dr, shift_dr, update_dr, tdi;
    logic        tdo, tdo_b;
    logic [31:0] cfi, cfo;
    logic [15:0] sfi;
    logic [3:0]  upd_valid, upd_ack;
    logic [23:0] cfi_b, cfo_b;
    logic [11:0] sfi_b;
    logic [2:0]  valid_b, ack_b;

    int checks = 0;
    int errors = 0;

    always #5 tck = ~tck;

    jtag_tdr_bank #(.N_CH(4), .N_CONF(8), .N_SCOPE(4), .INIT_VALUE(INIT_A)) dut (
        .tck(tck), .trst(trst), .select(select), .capture_dr(capture_dr),
        .shift_dr(shift_dr), .update_dr(update_dr), .tdi(tdi), .tdo(tdo),
        .cfi(cfi), .sfi(sfi), .cfo(cfo), .upd_valid(upd_valid), .upd_ack(upd_ack)
    );

    // Three-slot bank: channel index 3 is encodable but out of range.
    jtag_tdr_bank #(.N_CH(3), .N_CONF(8), .N_SCOPE(4), .INIT_VALUE(INIT_B)) dut_b (
        .tck(tck), .trst(trst), .select(select_b), .capture_dr(capture_dr),
        .shift_dr(shift_dr), .update_dr(update_dr), .tdi(tdi), .tdo(tdo_b),
        .cfi(cfi_b), .sfi(sfi_b), .cfo(cfo_b), .upd_valid(valid_b), .upd_ack(ack_b)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] mk_frame(input logic wr, input logic ovr,
                                             input logic [1:0] ch, input logic [7:0] conf);
        return {wr, ovr, ch, 4'h0, conf};
    endfunction

    // Capture, shift a full frame in (MSB first) while collecting tdo, then update.
    task automatic scan(input logic sel_a, input logic sel_b, input logic [15:0] fin,
                        input logic [3:0] ack_u, output logic [15:0] fout_a,
                        output logic [15:0] fout_b);
        select     = sel_a;
        select_b   = sel_b;
        capture_dr = 1'b1;
        @(negedge tck);
        capture_dr = 1'b0;
        for (int i = 0; i < L; i++) begin
            fout_a[L-1-i] = tdo;
            fout_b[L-1-i] = tdo_b;
            shift_dr      = 1'b1;
            tdi           = fin[L-1-i];
            @(negedge tck);
        end
        shift_dr  = 1'b0;
        update_dr = 1'b1;
        upd_ack   = ack_u;
        @(negedge tck);
        update_dr = 1'b0;
        upd_ack   = '0;
        select    = 1'b0;
        select_b  = 1'b0;
    endtask

    // ---------------- reference model (transaction level) ----------------
    logic [7:0] m_cfg [4];
    logic       m_ovr [4];
    logic       m_pend[4];
    logic       m_ovf [4];
    int         m_ptr;

    task automatic m_reset();
        for (int c = 0; c < 4; c++) begin
            m_cfg[c]  = INIT_A[c*8 +: 8];
            m_ovr[c]  = 1'b0;
            m_pend[c] = 1'b0;
            m_ovf[c]  = 1'b0;
        end
        m_ptr = 0;
    endtask

    task automatic m_capture(output logic [15:0] frame);
        frame = {m_ovf[m_ptr], m_ovr[m_ptr], 2'(m_ptr), sfi[m_ptr*4 +: 4], m_cfg[m_ptr]};
        m_ovf[m_ptr] = 1'b0;
    endtask

    task automatic m_update(input logic wr, input logic ovr, input int ch,
                            input logic [7:0] conf, input logic [3:0] ack);
        for (int c = 0; c < 4; c++) begin
            if (wr && c == ch) begin
                if (!m_pend[c] || ack[c]) begin
                    m_cfg[c]  = conf;
                    m_ovr[c]  = ovr;
                    m_pend[c] = 1'b1;
                end else begin
                    m_ovf[c] = 1'b1;
                end
            end else if (ack[c]) begin
                m_pend[c] = 1'b0;
            end
        end
        m_ptr = ch;
    endtask

    function automatic logic [31:0] m_cfo();
        logic [31:0] r;
        for (int c = 0; c < 4; c++) r[c*8 +: 8] = m_ovr[c] ? m_cfg[c] : cfi[c*8 +: 8];
        return r;
    endfunction

    function automatic logic [3:0] m_valid();
        logic [3:0] r;
        for (int c = 0; c < 4; c++) r[c] = m_pend[c];
        return r;
    endfunction

    // ---------------- directed table ----------------
    typedef struct {
        logic        wr;
        logic        ovr;
        logic [1:0]  ch;
        logic [7:0]  conf;
        logic [3:0]  ack_upd;
        logic [3:0]  ack_post;
        logic [15:0] exp_out;
        logic [3:0]  exp_valid;
        logic [31:0] exp_cfo;
        logic [3:0]  exp_valid_post;
    } vec_t;

    vec_t tbl[10];

    initial begin
        logic [15:0] fa, fb, exp_f;
        logic        r_wr, r_ovr;
        int          r_ch;
        logic [7:0]  r_conf;
        logic [3:0]  r_ack;

        // cfi=A5 everywhere, sfi[3]=9; INIT: ch0=44 ch1=2F ch2=6B ch3=8C
        tbl[0] = '{1'b1, 1'b1, 2'd2, 8'h3C, 4'h0, 4'h0, 16'h0044, 4'b0100, 32'hA53CA5A5, 4'b0100};
        tbl[1] = '{1'b1, 1'b1, 2'd2, 8'h55, 4'h0, 4'b0100, 16'h603C, 4'b0100, 32'hA53CA5A5, 4'b0000};
        tbl[2] = '{1'b0, 1'b0, 2'd2, 8'h00, 4'h0, 4'h0, 16'hE03C, 4'b0000, 32'hA53CA5A5, 4'b0000};
        tbl[3] = '{1'b1, 1'b1, 2'd1, 8'h81, 4'h0, 4'h0, 16'h603C, 4'b0010, 32'hA53C81A5, 4'b0010};
        tbl[4] = '{1'b1, 1'b1, 2'd1, 8'h7E, 4'b0010, 4'b0010, 16'h5081, 4'b0010, 32'hA53C7EA5, 4'b0000};
        tbl[5] = '{1'b0, 1'b0, 2'd1, 8'h00, 4'h0, 4'h0, 16'h507E, 4'b0000, 32'hA53C7EA5, 4'b0000};
        tbl[6] = '{1'b1, 1'b0, 2'd3, 8'hFF, 4'h0, 4'b1000, 16'h507E, 4'b1000, 32'hA53C7EA5, 4'b0000};
        tbl[7] = '{1'b0, 1'b0, 2'd3, 8'h00, 4'h0, 4'h0, 16'h39FF, 4'b0000, 32'hA53C7EA5, 4'b0000};
        // channel 5 in a 2-bit field wraps to 1
        tbl[8] = '{1'b1, 1'b0, 2'd1, 8'h12, 4'h0, 4'b0010, 16'h39FF, 4'b0010, 32'hA53CA5A5, 4'b0000};
        tbl[9] = '{1'b0, 1'b0, 2'd1, 8'h00, 4'h0, 4'h0, 16'h1012, 4'b0000, 32'hA53CA5A5, 4'b0000};

        trst = 1'b1; select = 1'b0; select_b = 1'b0; capture_dr = 1'b0;
        shift_dr = 1'b0; update_dr = 1'b0; tdi = 1'b0;
        cfi = 32'hA5A5A5A5; sfi = 16'h9000; upd_ack = '0;
        cfi_b = 24'hA5A5A5; sfi_b = '0; ack_b = '0;

        // Reset: two cycles
        @(negedge tck);
        @(negedge tck);
        trst = 1'b0;
        check("reset_tdo", tdo, 1'b0);
        check("reset_valid", upd_valid, 4'b0);
        check("reset_cfo", cfo, 32'hA5A5A5A5);
        check("reset_valid_b", valid_b, 3'b0);

        // Directed table
        for (int i = 0; i < 10; i++) begin
            scan(1'b1, 1'b0, mk_frame(tbl[i].wr, tbl[i].ovr, tbl[i].ch, tbl[i].conf),
                 tbl[i].ack_upd, fa, fb);
            check($sformatf("tbl%0d_capture", i), fa, tbl[i].exp_out);
            check($sformatf("tbl%0d_valid", i), upd_valid, tbl[i].exp_valid);
            check($sformatf("tbl%0d_cfo", i), cfo, tbl[i].exp_cfo);
            upd_ack = tbl[i].ack_post;
            @(negedge tck);
            upd_ack = '0;
            check($sformatf("tbl%0d_valid_post", i), upd_valid, tbl[i].exp_valid_post);
        end

        // Out-of-range channel on the 3-slot bank leaves everything alone
        scan(1'b0, 1'b1, mk_frame(1'b1, 1'b1, 2'd3, 8'h77), 4'h0, fa, fb);
        check("b_first_capture", fb, 16'h0055);
        check("b_cfo_after_oor", cfo_b, 24'hA5A5A5);
        check("b_valid_after_oor", valid_b, 3'b0);
        scan(1'b0, 1'b1, mk_frame(1'b0, 1'b0, 2'd3, 8'h00), 4'h0, fa, fb);
        check("b_ptr_unchanged", fb, 16'h0055);

        // Reset in the middle of a shift with a write pending
        scan(1'b1, 1'b0, mk_frame(1'b1, 1'b1, 2'd0, 8'h01), 4'h0, fa, fb);
        check("pre_rst_valid", upd_valid, 4'b0001);
        check("pre_rst_cfo", cfo, 32'hA53CA501);
        select = 1'b1;
        capture_dr = 1'b1;
        @(negedge tck);
        capture_dr = 1'b0;
        check("pre_rst_tdo_msb", tdo, 1'b0);
        shift_dr = 1'b1;
        tdi = 1'b1;
        @(negedge tck);
        check("pre_rst_tdo_ovr", tdo, 1'b1);
        trst = 1'b1;
        @(negedge tck);
        trst = 1'b0; shift_dr = 1'b0; select = 1'b0;
        check("mid_rst_tdo", tdo, 1'b0);
        check("mid_rst_valid", upd_valid, 4'b0);
        check("mid_rst_cfo", cfo, cfi);

        // Random scans against the model
        m_reset();
        for (int n = 0; n < 80; n++) begin
            cfi    = $urandom;
            sfi    = 16'($urandom);
            r_wr   = ($urandom_range(0, 3) != 0);
            r_ovr  = 1'($urandom);
            r_ch   = $urandom_range(0, 3);
            r_conf = 8'($urandom);
            r_ack  = 4'($urandom & $urandom & $urandom);
            m_capture(exp_f);
            m_update(r_wr, r_ovr, r_ch, r_conf, r_ack);
            scan(1'b1, 1'b0, mk_frame(r_wr, r_ovr, 2'(r_ch), r_conf), r_ack, fa, fb);
            check($sformatf("rnd%0d_capture", n), fa, exp_f);
            check($sformatf("rnd%0d_valid", n), upd_valid, m_valid());
            check($sformatf("rnd%0d_cfo", n), cfo, m_cfo());
            r_ack   = 4'($urandom & $urandom);
            upd_ack = r_ack;
            @(negedge tck);
            upd_ack = '0;
            for (int c = 0; c < 4; c++) if (r_ack[c]) m_pend[c] = 1'b0;
            check($sformatf("rnd%0d_valid_post", n), upd_valid, m_valid());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
